// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller.
// A single one-bit full_adder cell is stepped across a WIDTH-bit operand pair,
// LSB first, one bit per clock. Subtraction is performed as A + ~B + 1.
// Results are registered and held until the next completion or reset.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             Data_in_C,
    input  logic             Data_in_Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Data_out_Sum,
    output logic             Data_out_Carry,
    output logic             Data_out_Overflow
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cy_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    // Only the upper WIDTH-1 partial-sum bits need storage: the bit produced
    // on the final edge goes straight into the result register.
    logic [WIDTH-2:0]   s_sr_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               ovf_q;

    logic               fa_sum_s;
    logic               fa_co_s;
    logic [WIDTH-1:0]   s_next_s;

    full_adder u_full_adder (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .c_i  (cy_q),
        .s_o  (fa_sum_s),
        .co_o (fa_co_s)
    );

    // Partial sum after this edge's bit enters at the MSB.
    assign s_next_s = {fa_sum_s, s_sr_q};

    // Sequencer: operand capture, per-bit shifting and result latching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            cy_q    <= 1'b0;
            a_sr_q  <= {WIDTH{1'b0}};
            b_sr_q  <= {WIDTH{1'b0}};
            s_sr_q  <= {(WIDTH-1){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr_q  <= Data_in_A;
                        b_sr_q  <= Data_in_Sub ? ~Data_in_B : Data_in_B;
                        cy_q    <= Data_in_Sub ? 1'b1 : Data_in_C;
                        cnt_q   <= {CNT_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
                    s_sr_q <= s_next_s[WIDTH-1:1];
                    cy_q   <= fa_co_s;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        sum_q   <= s_next_s;
                        carry_q <= fa_co_s;
                        // Carry into the MSB stage is the current cy.
                        ovf_q   <= cy_q ^ fa_co_s;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign Data_out_Sum      = sum_q;
    assign Data_out_Carry    = carry_q;
    assign Data_out_Overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized
// operations compared against an integer-arithmetic reference model.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         sub_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         carry_out;
    logic         ovf_out;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_sum;
    logic         prev_carry;
    logic         prev_ovf;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .Data_in_A         (a_in),
        .Data_in_B         (b_in),
        .Data_in_C         (c_in),
        .Data_in_Sub       (sub_in),
        .busy              (busy),
        .done              (done),
        .Data_out_Sum      (sum_out),
        .Data_out_Carry    (carry_out),
        .Data_out_Overflow (ovf_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic sub);
        int ua, ub, sa, sb, full, sres;
        logic cy, ov;
        logic [W-1:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        if (sub) begin
            full = ua - ub;
            cy   = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + int'(c);
            cy   = (full >= (1 << W));
            sres = sa + sb + int'(c);
        end
        s  = full[W-1:0];
        ov = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
        return {ov, cy, s};
    endfunction

    // One full operation; with disturb set, inputs (including start) are
    // scrambled while the operation runs.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic sub, input logic disturb);
        logic [W+1:0] exp;
        exp = ref_model(a, b, c, sub);
        @(negedge clk);
        a_in = a; b_in = b; c_in = c; sub_in = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("accept_busy", {31'd0, busy}, 32'd1);
        check_eq("accept_done", {31'd0, done}, 32'd0);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (i < W) begin
                check_eq("run_busy", {31'd0, busy}, 32'd1);
                check_eq("run_done", {31'd0, done}, 32'd0);
                check_eq("hold_sum", {24'd0, sum_out}, {24'd0, prev_sum});
                check_eq("hold_flags", {30'd0, ovf_out, carry_out}, {30'd0, prev_ovf, prev_carry});
                if (disturb) begin
                    a_in   = W'($urandom);
                    b_in   = W'($urandom);
                    c_in   = 1'($urandom);
                    sub_in = 1'($urandom);
                    start  = (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            end else begin
                check_eq("end_done", {31'd0, done}, 32'd1);
                check_eq("end_busy", {31'd0, busy}, 32'd0);
                check_eq("sum", {24'd0, sum_out}, {24'd0, exp[W-1:0]});
                check_eq("carry", {31'd0, carry_out}, {31'd0, exp[W]});
                check_eq("overflow", {31'd0, ovf_out}, {31'd0, exp[W+1]});
                start = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("post_done", {31'd0, done}, 32'd0);
        check_eq("post_busy", {31'd0, busy}, 32'd0);
        prev_sum   = exp[W-1:0];
        prev_carry = exp[W];
        prev_ovf   = exp[W+1];
    endtask

    initial begin
        logic [W+1:0] exp;
        int done_cnt;
        rst = 1'b1; start = 1'b0;
        a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0;
        prev_sum = '0; prev_carry = 1'b0; prev_ovf = 1'b0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sum", {24'd0, sum_out}, 32'd0);
        check_eq("rst_flags", {30'd0, ovf_out, carry_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        check_eq("dir_5a_3c", {22'd0, ovf_out, carry_out, sum_out}, {22'd0, 2'b10, 8'h96});
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        check_eq("dir_ff_01", {22'd0, ovf_out, carry_out, sum_out}, {22'd0, 2'b01, 8'h00});
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        check_eq("dir_ff_ff_c", {22'd0, ovf_out, carry_out, sum_out}, {22'd0, 2'b01, 8'hFF});
        run_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
        check_eq("dir_sub_10_20", {22'd0, ovf_out, carry_out, sum_out}, {22'd0, 2'b00, 8'hF0});
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
        check_eq("dir_sub_80_01", {22'd0, ovf_out, carry_out, sum_out}, {22'd0, 2'b11, 8'h7F});

        // Start pulsed and operands changed mid-run: first result unaffected.
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        check_eq("disturb_5a_3c", {24'd0, sum_out}, 32'h96);

        // Start held high: completions after E8, E17, E26.
        exp = ref_model(8'h21, 8'h13, 1'b1, 1'b0);
        done_cnt = 0;
        @(negedge clk);
        a_in = 8'h21; b_in = 8'h13; c_in = 1'b1; sub_in = 1'b0; start = 1'b1;
        for (int e = 0; e <= 26; e++) begin
            @(posedge clk);
            #1;
            check_eq("hold_start_done", {31'd0, done},
                     {31'd0, (e == 8 || e == 17 || e == 26)});
            if (done) begin
                done_cnt++;
                check_eq("hold_start_sum", {24'd0, sum_out}, {24'd0, exp[W-1:0]});
            end
        end
        @(negedge clk);
        start = 1'b0;
        check_eq("hold_start_count", done_cnt, 32'd3);
        @(negedge clk);
        check_eq("hold_start_idle", {31'd0, busy}, 32'd0);
        prev_sum = exp[W-1:0]; prev_carry = exp[W]; prev_ovf = exp[W+1];

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h3C; c_in = 1'b0; sub_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_sum", {24'd0, sum_out}, 32'd0);
        check_eq("midrst_flags", {30'd0, ovf_out, carry_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("midrst_no_done", {30'd0, done, busy}, 32'd0);
        end
        prev_sum = '0; prev_carry = 1'b0; prev_ovf = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        check_eq("after_rst_sum", {24'd0, sum_out}, 32'h02);

        // Randomized operations with input scrambling during the run.
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
